// File: rtl/hex_pio_pkg.sv
// Shared definitions for the hex-digit PIO: register offsets and 7-segment encoding.
package hex_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLR       = 3'd2;
  localparam logic [2:0] ADDR_BLANK     = 3'd3;
  localparam logic [2:0] ADDR_BLINK     = 3'd4;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Active-low segments, bit 6 = g down to bit 0 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_pio_blink_timer.sv
// Blink half-period divider: toggles the phase every blink_div+1 cycles, restarts on reload.
module hex_pio_blink_timer #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] blink_div,
  input  logic             div_wr,
  output logic             blink_phase
);

  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;

  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    // A reload beats a terminal-count toggle landing on the same edge.
    if (div_wr || (blink_div == '0)) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt_reg == blink_div) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  assign blink_phase = phase_reg;

endmodule

// File: rtl/hex_digits_pio_gen.sv
// Avalon-MM hex-digit PIO with set/clear, blank/blink masks and a blink timer.
// Define HEX_PIO_SEG_DECODE_EN to add the registered 7-segment output seg_out.
module hex_digits_pio_gen
  import hex_pio_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DIV_W         = 25,
  parameter int BLINK_DIV_RST = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [NUM_DIGITS-1:0]   digit_en,
`ifdef HEX_PIO_SEG_DECODE_EN
  output logic [7*NUM_DIGITS-1:0] seg_out,
`endif
  output logic                    blink_phase
);

  localparam int DW = 4 * NUM_DIGITS;

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
    $error("hex_digits_pio_gen: NUM_DIGITS must be 1..8");
  end
  if ((DIV_W < 1) || (DIV_W > 32) || ((longint'(BLINK_DIV_RST) >> DIV_W) != 0)) begin : g_bad_div
    $error("hex_digits_pio_gen: BLINK_DIV_RST must fit in DIV_W (1..32) bits");
  end

  logic [DW-1:0]         data_reg, data_next;
  logic [NUM_DIGITS-1:0] blank_reg, blank_next;
  logic [NUM_DIGITS-1:0] blink_reg, blink_next;
  logic [DIV_W-1:0]      div_reg, div_next;
  logic [NUM_DIGITS-1:0] digit_en_reg, digit_en_next;
  logic                  wr_en, div_wr;
  logic [DW-1:0]         wd_data;
  logic                  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign div_wr    = wr_en && (address == ADDR_BLINK_DIV);
  assign wd_data   = writedata[DW-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_next  = data_reg;
    blank_next = blank_reg;
    blink_next = blink_reg;
    div_next   = div_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      data_next  = wd_data;
        ADDR_SET:       data_next  = data_reg | wd_data;
        ADDR_CLR:       data_next  = data_reg & ~wd_data;
        ADDR_BLANK:     blank_next = writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:     blink_next = writedata[NUM_DIGITS-1:0];
        ADDR_BLINK_DIV: div_next   = writedata[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  hex_pio_blink_timer #(.DIV_W(DIV_W)) u_blink_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .blink_div   (div_reg),
    .div_wr      (div_wr),
    .blink_phase (blink_phase)
  );

  // Enables are computed from the current (pre-edge) masks and phase.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_en
    assign digit_en_next[gi] = ~blank_reg[gi] & (~blink_reg[gi] | blink_phase);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_reg     <= '0;
      blank_reg    <= '0;
      blink_reg    <= '0;
      div_reg      <= DIV_W'(BLINK_DIV_RST);
      digit_en_reg <= '1;
    end else begin
      data_reg     <= data_next;
      blank_reg    <= blank_next;
      blink_reg    <= blink_next;
      div_reg      <= div_next;
      digit_en_reg <= digit_en_next;
    end
  end

`ifdef HEX_PIO_SEG_DECODE_EN
  logic [7*NUM_DIGITS-1:0] seg_reg, seg_next;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
    assign seg_next[gi*7 +: 7] = digit_en_next[gi] ? hex_to_seg(data_reg[gi*4 +: 4]) : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_reg <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign seg_out = seg_reg;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data_reg);
      ADDR_BLANK:     readdata = 32'(blank_reg);
      ADDR_BLINK:     readdata = 32'(blink_reg);
      ADDR_BLINK_DIV: readdata = 32'(div_reg);
      ADDR_STATUS: begin
        readdata[0]    = blink_phase;
        readdata[11:8] = 4'(NUM_DIGITS);
      end
      default: ;
    endcase
  end

  assign out_port = data_reg;
  assign digit_en = digit_en_reg;

endmodule

// File: tb/tb_hex_digits_pio_gen.sv
// Scoreboard bench for hex_digits_pio_gen against a cycle-count reference model.
module tb_hex_digits_pio_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic [3:0]  digit_en;
  logic        blink_phase;
`ifdef HEX_PIO_SEG_DECODE_EN
  logic [27:0] seg_out;
`endif

  hex_digits_pio_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .digit_en    (digit_en),
`ifdef HEX_PIO_SEG_DECODE_EN
    .seg_out     (seg_out),
`endif
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state, updated once per rising edge.
  logic [15:0] m_data;
  logic [3:0]  m_blank, m_blink, m_en;
  logic [24:0] m_div;
  logic        m_phase;
  logic [27:0] m_seg;
  int          m_since;   // edges since the last reload of the blink timer
  bit          chk_on = 1'b0;
  bit          rd_flag = 1'b0;
  logic [31:0] exp_q[$];
  logic [2:0]  addr_q[$];

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0: return {16'd0, m_data};
      3'd3: return {28'd0, m_blank};
      3'd4: return {28'd0, m_blink};
      3'd5: return {7'd0, m_div};
      3'd6: return 32'h400 | {31'd0, m_phase};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0]  en_n;
    logic [27:0] seg_n;
    bit          w, reload;
    int unsigned p;
    w = reset_n && chipselect && !write_n;
    reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en_n[i] = !m_blank[i] && (!m_blink[i] || m_phase);
      seg_n[i*7 +: 7] = en_n[i] ? ref_seg(m_data[i*4 +: 4]) : 7'h7F;
    end
    if (!reset_n) begin
      m_data = 16'd0; m_blank = 4'd0; m_blink = 4'd0; m_div = 25'd25000000;
      m_since = 0; m_en = 4'hF; m_seg = {4{7'h40}};
    end else begin
      if (w) begin
        case (address)
          3'd0: m_data = writedata[15:0];
          3'd1: m_data = m_data | writedata[15:0];
          3'd2: m_data = m_data & ~writedata[15:0];
          3'd3: m_blank = writedata[3:0];
          3'd4: m_blink = writedata[3:0];
          3'd5: begin m_div = writedata[24:0]; reload = 1'b1; end
          default: ;
        endcase
      end
      if (reload) m_since = 0; else m_since++;
      m_en = en_n;
      m_seg = seg_n;
    end
    p = m_div;
    m_phase = (p == 0) ? 1'b1 : (((m_since / (p + 1)) % 2) == 0);
  endtask

  task automatic cyc(input bit rn, input bit cs, input bit wn, input logic [2:0] a,
                     input logic [31:0] wd, input bit rd);
    @(posedge clk);
    model_step();
    chk_on = 1'b1;
    #1;
    reset_n = rn; chipselect = cs; write_n = wn; address = a; writedata = wd;
    rd_flag = rd;
    if (rd) begin
      exp_q.push_back(exp_read(a));
      addr_q.push_back(a);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    cyc(1, 1, 0, a, wd, 0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1, 1'($urandom_range(0, 1)), 1, a, 32'd0, 1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle outputs and any read that is in flight.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_port", {16'd0, out_port}, {16'd0, m_data});
      chk("digit_en", {28'd0, digit_en}, {28'd0, m_en});
      chk("blink_phase", {31'd0, blink_phase}, {31'd0, m_phase});
`ifdef HEX_PIO_SEG_DECODE_EN
      chk("seg_out", {4'd0, seg_out}, {4'd0, m_seg});
`endif
      if (rd_flag) begin
        if (exp_q.size() == 0) begin
          chk("rd_queue_empty", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          logic [2:0]  a;
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          $display("read addr=%0d data=%h expected=%h", a, readdata, e);
          chk("readdata", readdata, e);
        end
      end
    end
  end

  initial begin
    bit found;
    // Reset and register map after reset.
    repeat (3) cyc(0, 0, 1, 3'd0, 32'd0, 0);
    for (int a = 0; a < 8; a++) rd(3'(a));

    // DATA / SET / CLR.
    wr(3'd0, 32'hFFFF_1234);
    wr(3'd1, 32'h0000_000F);
    wr(3'd2, 32'h0000_0030);
    rd(3'd0); rd(3'd1); rd(3'd2);

    // Blink on digit 1 with a 4-cycle half period.
    wr(3'd5, 32'd3);
    wr(3'd4, 32'h2);
    repeat (20) rd(3'd6);

    // Reload exactly on a terminal count.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_div != 0 && (m_since % (int'(m_div) + 1)) == int'(m_div)) found = 1'b1;
      else rd(3'd6);
    end
    chk("terminal_found", {31'd0, found}, 32'd1);
    wr(3'd5, 32'd3);
    repeat (8) rd(3'd6);
    wr(3'd5, 32'd0);
    repeat (30) rd(3'd6);

    // Blank overrides blink.
    wr(3'd5, 32'd3);
    wr(3'd3, 32'h4);
    wr(3'd4, 32'h6);
    repeat (12) rd(3'd6);

    // One-cycle reset while blinking.
    cyc(0, 0, 1, 3'd6, 32'd0, 1);
    for (int a = 0; a < 7; a++) rd(3'(a));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
      cyc(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a, d, 1);
    end

    cyc(1, 0, 1, 3'd0, 32'd0, 0);
    @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
